// File: rtl/unidade_controle_multiciclo_pkg.sv
// Shared definitions for the multicycle MIPS control unit: opcodes, state
// codes, datapath select codes and the control-word layout.
package pkg_controle_mips;

    // Instruction opcodes (IR[31:26])
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    // FSM state codes; 13..15 are unused and recover to FETCH
    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADDR  = 4'd2,
        MEM_READ  = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WRITE = 4'd5,
        EXECUTE   = 4'd6,
        R_WB      = 4'd7,
        BRANCH    = 4'd8,
        JUMP      = 4'd9,
        ADDI_EXEC = 4'd10,
        ADDI_WB   = 4'd11,
        ILLEGAL   = 4'd12
    } estado_t;

    // ALU operation codes
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALU operand B selects
    localparam logic [1:0] SRCB_REGB   = 2'b00;
    localparam logic [1:0] SRCB_QUATRO = 2'b01;
    localparam logic [1:0] SRCB_IMED   = 2'b10;
    localparam logic [1:0] SRCB_DESLOC = 2'b11;

    // PC source selects
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Full set of datapath controls produced in one cycle
    typedef struct packed {
        logic       pcWrite;
        logic       pcWriteCond;
        logic       iorD;
        logic       memRead;
        logic       memWrite;
        logic       irWrite;
        logic       memtoReg;
        logic       regDst;
        logic       escReg;
        logic       aluSrcA;
        logic [1:0] aluSrcB;
        logic [1:0] aluOp;
        logic [1:0] pcSource;
        logic       excecao;
    } controle_t;

    // Final states that always retire their instruction on the way back to
    // FETCH. MEM_WRITE also retires, but only once memory acknowledges.
    function automatic logic estadoRetira(input estado_t e);
        return (e == MEM_WB) || (e == R_WB) || (e == BRANCH) ||
               (e == JUMP)   || (e == ADDI_WB);
    endfunction

endpackage

// File: rtl/unidade_controle_multiciclo_contador.sv
// Retired-instruction counter: width-parameterised, synchronous clear,
// increment enable, wraps naturally from all-ones to zero.
module contador_instrucoes
#(
    parameter int LARGURA = 32
)
(
    input  logic               clk,
    input  logic               srst,
    input  logic               clear,
    input  logic               enable,
    output logic [LARGURA-1:0] contagem
);

    logic [LARGURA-1:0] contagemReg;

    // Count register: clear has priority over increment
    always_ff @(posedge clk) begin
        if (srst || clear) begin
            contagemReg <= '0;
        end else if (enable) begin
            contagemReg <= contagemReg + 1'b1;
        end
    end

    assign contagem = contagemReg;

endmodule

// File: rtl/unidade_controle_multiciclo.sv
// Multicycle MIPS control unit: sequences fetch/decode/execute/memory/
// write-back, drives every datapath control and counts retired instructions.
module unidade_controle_multiciclo
    import pkg_controle_mips::*;
#(
    parameter int LARGURA_CONT = 32
)
(
    input  logic                    clock,
    input  logic                    reset,
    input  logic [5:0]              Opcode,
    input  logic                    MemPronto,
    output logic                    PCWrite,
    output logic                    PCWriteCond,
    output logic                    IorD,
    output logic                    MemRead,
    output logic                    MemWrite,
    output logic                    IRWrite,
    output logic                    MemtoReg,
    output logic                    RegDst,
    output logic                    EscReg,
    output logic                    ALUSrcA,
    output logic [1:0]              ALUSrcB,
    output logic [1:0]              ALUOp,
    output logic [1:0]              PCSource,
    output logic                    Excecao,
    output logic [3:0]              Estado,
    output logic [LARGURA_CONT-1:0] InstrConcluidas
);

    estado_t                 estadoReg;
    controle_t               controle;
    logic                    incrementa;
    logic [LARGURA_CONT-1:0] contagem;

    // State register with next-state selection; Opcode is only looked at in
    // DECODE and MEM_ADDR, MemPronto only in the three memory states
    always_ff @(posedge clock) begin
        if (reset) begin
            estadoReg <= FETCH;
        end else begin
            case (estadoReg)
                FETCH: begin
                    if (MemPronto) estadoReg <= DECODE;
                end
                DECODE: begin
                    case (Opcode)
                        OP_LW, OP_SW: estadoReg <= MEM_ADDR;
                        OP_R:         estadoReg <= EXECUTE;
                        OP_BEQ:       estadoReg <= BRANCH;
                        OP_J:         estadoReg <= JUMP;
                        OP_ADDI:      estadoReg <= ADDI_EXEC;
                        default:      estadoReg <= ILLEGAL;
                    endcase
                end
                MEM_ADDR: begin
                    // Only lw and sw can reach here, so anything not lw is sw
                    if (Opcode == OP_LW) estadoReg <= MEM_READ;
                    else                 estadoReg <= MEM_WRITE;
                end
                MEM_READ: begin
                    if (MemPronto) estadoReg <= MEM_WB;
                end
                MEM_WRITE: begin
                    if (MemPronto) estadoReg <= FETCH;
                end
                EXECUTE:   estadoReg <= R_WB;
                ADDI_EXEC: estadoReg <= ADDI_WB;
                MEM_WB, R_WB, BRANCH, JUMP, ADDI_WB, ILLEGAL: estadoReg <= FETCH;
                default:   estadoReg <= FETCH;
            endcase
        end
    end

    // Output decode from the state register; only FETCH looks at MemPronto,
    // so EscReg and the other write-back controls stay glitch-free. Reset
    // masks everything so an aborted instruction cannot write anything.
    always_comb begin
        controle = '0;
        case (estadoReg)
            FETCH: begin
                controle.memRead = 1'b1;
                controle.aluSrcB = SRCB_QUATRO;
                controle.irWrite = MemPronto;
                controle.pcWrite = MemPronto;
            end
            DECODE: begin
                controle.aluSrcB = SRCB_DESLOC;
            end
            MEM_ADDR: begin
                controle.aluSrcA = 1'b1;
                controle.aluSrcB = SRCB_IMED;
            end
            MEM_READ: begin
                controle.memRead = 1'b1;
                controle.iorD    = 1'b1;
            end
            MEM_WB: begin
                controle.escReg   = 1'b1;
                controle.memtoReg = 1'b1;
            end
            MEM_WRITE: begin
                controle.memWrite = 1'b1;
                controle.iorD     = 1'b1;
            end
            EXECUTE: begin
                controle.aluSrcA = 1'b1;
                controle.aluOp   = ALUOP_FUNCT;
            end
            R_WB: begin
                controle.escReg = 1'b1;
                controle.regDst = 1'b1;
            end
            BRANCH: begin
                controle.aluSrcA     = 1'b1;
                controle.aluOp       = ALUOP_SUB;
                controle.pcWriteCond = 1'b1;
                controle.pcSource    = PCSRC_ALUOUT;
            end
            JUMP: begin
                controle.pcWrite  = 1'b1;
                controle.pcSource = PCSRC_JUMP;
            end
            ADDI_EXEC: begin
                controle.aluSrcA = 1'b1;
                controle.aluSrcB = SRCB_IMED;
            end
            ADDI_WB: begin
                controle.escReg = 1'b1;
            end
            ILLEGAL: begin
                // PC already holds PC+4 from FETCH; just flag the fault
                controle.excecao = 1'b1;
            end
            default: begin
                controle = '0;
            end
        endcase
        if (reset) begin
            controle = '0;
        end
    end

    // Retirement happens on the edge that returns a completed instruction
    // to FETCH; ILLEGAL and the unused codes never count
    always_comb begin
        incrementa = 1'b0;
        if (!reset) begin
            incrementa = estadoRetira(estadoReg) ||
                         ((estadoReg == MEM_WRITE) && MemPronto);
        end
    end

    contador_instrucoes #(
        .LARGURA (LARGURA_CONT)
    ) u_contador (
        .clk      (clock),
        .srst     (reset),
        .clear    (1'b0),
        .enable   (incrementa),
        .contagem (contagem)
    );

    assign PCWrite         = controle.pcWrite;
    assign PCWriteCond     = controle.pcWriteCond;
    assign IorD            = controle.iorD;
    assign MemRead         = controle.memRead;
    assign MemWrite        = controle.memWrite;
    assign IRWrite         = controle.irWrite;
    assign MemtoReg        = controle.memtoReg;
    assign RegDst          = controle.regDst;
    assign EscReg          = controle.escReg;
    assign ALUSrcA         = controle.aluSrcA;
    assign ALUSrcB         = controle.aluSrcB;
    assign ALUOp           = controle.aluOp;
    assign PCSource        = controle.pcSource;
    assign Excecao         = controle.excecao;
    assign Estado          = reset ? 4'd0 : estadoReg;
    assign InstrConcluidas = reset ? '0 : contagem;

endmodule

// File: tb/tb_unidade_controle_multiciclo.sv
// Directed bench for the multicycle control unit: per-cycle state and
// control-word checks against hand-written tables.
module tb_unidade_controle_multiciclo;

    localparam int LC = 4;

    logic          clock;
    logic          reset;
    logic [5:0]    Opcode;
    logic          MemPronto;
    logic          PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic          MemtoReg, RegDst, EscReg, ALUSrcA, Excecao;
    logic [1:0]    ALUSrcB, ALUOp, PCSource;
    logic [3:0]    Estado;
    logic [LC-1:0] InstrConcluidas;

    int checks   = 0;
    int failures = 0;
    logic [LC-1:0] contEsp;

    // Bit order: PCW PCWC IorD MRd MWr IRW M2R RDst Esc SrcA SrcB[2] Op[2] PCSrc[2] Exc
    logic [16:0] sinais;
    assign sinais = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                     MemtoReg, RegDst, EscReg, ALUSrcA, ALUSrcB, ALUOp,
                     PCSource, Excecao};

    localparam logic [16:0] S_ZERO   = 17'b0_0_0_0_0_0_0_0_0_0_00_00_00_0;
    localparam logic [16:0] S_FWAIT  = 17'b0_0_0_1_0_0_0_0_0_0_01_00_00_0;
    localparam logic [16:0] S_FRDY   = 17'b1_0_0_1_0_1_0_0_0_0_01_00_00_0;
    localparam logic [16:0] S_DEC    = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_0;
    localparam logic [16:0] S_MADDR  = 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
    localparam logic [16:0] S_MREAD  = 17'b0_0_1_1_0_0_0_0_0_0_00_00_00_0;
    localparam logic [16:0] S_MWB    = 17'b0_0_0_0_0_0_1_0_1_0_00_00_00_0;
    localparam logic [16:0] S_MWRITE = 17'b0_0_1_0_1_0_0_0_0_0_00_00_00_0;
    localparam logic [16:0] S_EXEC   = 17'b0_0_0_0_0_0_0_0_0_1_00_10_00_0;
    localparam logic [16:0] S_RWB    = 17'b0_0_0_0_0_0_0_1_1_0_00_00_00_0;
    localparam logic [16:0] S_BEQ    = 17'b0_1_0_0_0_0_0_0_0_1_00_01_01_0;
    localparam logic [16:0] S_JUMP   = 17'b1_0_0_0_0_0_0_0_0_0_00_00_10_0;
    localparam logic [16:0] S_AEXEC  = 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
    localparam logic [16:0] S_AWB    = 17'b0_0_0_0_0_0_0_0_1_0_00_00_00_0;
    localparam logic [16:0] S_ILL    = 17'b0_0_0_0_0_0_0_0_0_0_00_00_00_1;

    unidade_controle_multiciclo #(.LARGURA_CONT(LC)) dut (
        .clock           (clock),
        .reset           (reset),
        .Opcode          (Opcode),
        .MemPronto       (MemPronto),
        .PCWrite         (PCWrite),
        .PCWriteCond     (PCWriteCond),
        .IorD            (IorD),
        .MemRead         (MemRead),
        .MemWrite        (MemWrite),
        .IRWrite         (IRWrite),
        .MemtoReg        (MemtoReg),
        .RegDst          (RegDst),
        .EscReg          (EscReg),
        .ALUSrcA         (ALUSrcA),
        .ALUSrcB         (ALUSrcB),
        .ALUOp           (ALUOp),
        .PCSource        (PCSource),
        .Excecao         (Excecao),
        .Estado          (Estado),
        .InstrConcluidas (InstrConcluidas)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic test_reset();
        reset = 1'b1; MemPronto = 1'b0; Opcode = 6'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clock); #1;
            checks++;
            if (sinais !== S_ZERO || Estado !== 4'd0 || InstrConcluidas !== '0) begin
                failures++;
                $display("FAIL reset_outputs cycle=%0d got sig=%b st=%0d cnt=%0d want sig=%b st=0 cnt=0",
                         i, sinais, Estado, InstrConcluidas, S_ZERO);
            end
        end
        reset = 1'b0; #1;
        checks++;
        if (Estado !== 4'd0 || sinais !== S_FWAIT || InstrConcluidas !== '0) begin
            failures++;
            $display("FAIL reset_release got st=%0d sig=%b cnt=%0d want st=0 sig=%b cnt=0",
                     Estado, sinais, InstrConcluidas, S_FWAIT);
        end
        contEsp = '0;
        @(posedge clock); #1;
        $display("reset done st=%0d cnt=%0d", Estado, InstrConcluidas);
    endtask

    task automatic test_lw();
        logic [3:0]  est [5] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
        logic [16:0] sig [5] = '{S_FRDY, S_DEC, S_MADDR, S_MREAD, S_MWB};
        Opcode = 6'b100011; MemPronto = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (Estado !== est[i] || sinais !== sig[i]) begin
                failures++;
                $display("FAIL lw_step%0d got st=%0d sig=%b want st=%0d sig=%b",
                         i, Estado, sinais, est[i], sig[i]);
            end
            @(posedge clock); #1;
        end
        contEsp = contEsp + 1'b1;
        checks++;
        if (Estado !== 4'd0 || InstrConcluidas !== contEsp) begin
            failures++;
            $display("FAIL lw_retire got st=%0d cnt=%0d want st=0 cnt=%0d", Estado, InstrConcluidas, contEsp);
        end
        $display("lw retired cnt=%0d", InstrConcluidas);
    endtask

    task automatic test_sw_waits();
        // one FETCH wait, then three MEM_WRITE waits
        logic [3:0]  est [8] = '{4'd0, 4'd0, 4'd1, 4'd2, 4'd5, 4'd5, 4'd5, 4'd5};
        logic [16:0] sig [8] = '{S_FWAIT, S_FRDY, S_DEC, S_MADDR,
                                 S_MWRITE, S_MWRITE, S_MWRITE, S_MWRITE};
        logic        mp  [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        Opcode = 6'b101011;
        for (int i = 0; i < 8; i++) begin
            MemPronto = mp[i]; #1;
            checks++;
            if (Estado !== est[i] || sinais !== sig[i] || InstrConcluidas !== contEsp) begin
                failures++;
                $display("FAIL sw_step%0d got st=%0d sig=%b cnt=%0d want st=%0d sig=%b cnt=%0d",
                         i, Estado, sinais, InstrConcluidas, est[i], sig[i], contEsp);
            end
            @(posedge clock); #1;
        end
        contEsp = contEsp + 1'b1;
        checks++;
        if (Estado !== 4'd0 || InstrConcluidas !== contEsp) begin
            failures++;
            $display("FAIL sw_retire got st=%0d cnt=%0d want st=0 cnt=%0d", Estado, InstrConcluidas, contEsp);
        end
        $display("sw retired cnt=%0d", InstrConcluidas);
    endtask

    task automatic test_sequence();
        // R, beq, j, addi back to back: 4+3+3+4 = 14 cycles
        logic [5:0]  op  [14] = '{6'b000000, 6'b000000, 6'b000000, 6'b000000,
                                  6'b000100, 6'b000100, 6'b000100,
                                  6'b000010, 6'b000010, 6'b000010,
                                  6'b001000, 6'b001000, 6'b001000, 6'b001000};
        logic [3:0]  est [14] = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0, 4'd1, 4'd8,
                                  4'd0, 4'd1, 4'd9, 4'd0, 4'd1, 4'd10, 4'd11};
        logic [16:0] sig [14] = '{S_FRDY, S_DEC, S_EXEC, S_RWB, S_FRDY, S_DEC, S_BEQ,
                                  S_FRDY, S_DEC, S_JUMP, S_FRDY, S_DEC, S_AEXEC, S_AWB};
        logic [LC-1:0] base;
        base = contEsp;
        MemPronto = 1'b1;
        for (int i = 0; i < 14; i++) begin
            Opcode = op[i]; #1;
            checks++;
            if (Estado !== est[i] || sinais !== sig[i]) begin
                failures++;
                $display("FAIL seq_step%0d got st=%0d sig=%b want st=%0d sig=%b",
                         i, Estado, sinais, est[i], sig[i]);
            end
            @(posedge clock); #1;
        end
        contEsp = base + 4'd4;
        checks++;
        if (Estado !== 4'd0 || InstrConcluidas !== contEsp) begin
            failures++;
            $display("FAIL seq_retire got st=%0d cnt=%0d want st=0 cnt=%0d", Estado, InstrConcluidas, contEsp);
        end
        $display("R/beq/j/addi retired cnt=%0d", InstrConcluidas);
    endtask

    task automatic test_illegal();
        logic [3:0]  est [4] = '{4'd0, 4'd1, 4'd12, 4'd0};
        logic [16:0] sig [4] = '{S_FRDY, S_DEC, S_ILL, S_FWAIT};
        logic        mp  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        Opcode = 6'b111111;
        for (int i = 0; i < 4; i++) begin
            MemPronto = mp[i]; #1;
            checks++;
            if (Estado !== est[i] || sinais !== sig[i] || InstrConcluidas !== contEsp) begin
                failures++;
                $display("FAIL illegal_step%0d got st=%0d sig=%b cnt=%0d want st=%0d sig=%b cnt=%0d",
                         i, Estado, sinais, InstrConcluidas, est[i], sig[i], contEsp);
            end
            @(posedge clock); #1;
        end
        $display("illegal opcode handled cnt=%0d", InstrConcluidas);
    endtask

    task automatic test_reset_midop();
        logic [3:0]  est [4] = '{4'd0, 4'd1, 4'd2, 4'd3};
        logic [16:0] sig [4] = '{S_FRDY, S_DEC, S_MADDR, S_MREAD};
        logic        mp  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        Opcode = 6'b100011;
        for (int i = 0; i < 4; i++) begin
            MemPronto = mp[i]; #1;
            checks++;
            if (Estado !== est[i] || sinais !== sig[i]) begin
                failures++;
                $display("FAIL midop_step%0d got st=%0d sig=%b want st=%0d sig=%b",
                         i, Estado, sinais, est[i], sig[i]);
            end
            @(posedge clock); #1;
        end
        // still waiting in MEM_READ; abort with reset
        reset = 1'b1; #1;
        checks++;
        if (sinais !== S_ZERO || Estado !== 4'd0) begin
            failures++;
            $display("FAIL midop_reset_mask got st=%0d sig=%b want st=0 sig=%b", Estado, sinais, S_ZERO);
        end
        @(posedge clock); #1;
        reset = 1'b0; MemPronto = 1'b0; #1;
        contEsp = '0;
        checks++;
        if (Estado !== 4'd0 || sinais !== S_FWAIT || InstrConcluidas !== contEsp) begin
            failures++;
            $display("FAIL midop_after got st=%0d sig=%b cnt=%0d want st=0 sig=%b cnt=0",
                     Estado, sinais, InstrConcluidas, S_FWAIT);
        end
        @(posedge clock); #1;
        $display("reset mid-operation st=%0d cnt=%0d", Estado, InstrConcluidas);
    endtask

    task automatic test_wrap();
        Opcode = 6'b000010; MemPronto = 1'b1;
        for (int n = 0; n < 16; n++) begin
            repeat (3) @(posedge clock);
            #1;
            contEsp = contEsp + 1'b1;
            if (n == 14) begin
                checks++;
                if (InstrConcluidas !== 4'hF || Estado !== 4'd0) begin
                    failures++;
                    $display("FAIL wrap_allones got cnt=%0d st=%0d want cnt=15 st=0", InstrConcluidas, Estado);
                end
            end
        end
        checks++;
        if (InstrConcluidas !== 4'h0 || contEsp !== 4'h0) begin
            failures++;
            $display("FAIL wrap_zero got cnt=%0d want cnt=0", InstrConcluidas);
        end
        $display("counter wrap cnt=%0d", InstrConcluidas);
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sw_waits();
        test_sequence();
        test_illegal();
        test_reset_midop();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
